// File: rtl/note_rec_sequencer_pkg.sv
// Shared definitions for the note record/playback sequencer:
// state encoding, note codes and the record-data helper.
package note_rec_sequencer_pkg;

  localparam int NOTE_W    = 6;
  localparam int KEY_COUNT = 48;

  localparam logic [NOTE_W-1:0] REST = 6'd63;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RECORD = 2'b01;
  localparam logic [1:0] ST_PLAY   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_RECORD = ST_RECORD,
    S_PLAY   = ST_PLAY
  } seq_state_t;

  // Code written to the note RAM for one beat: the pressed key, or REST.
  function automatic logic [NOTE_W-1:0] rec_code(input logic valid,
                                                 input logic [NOTE_W-1:0] note);
    return valid ? note : REST;
  endfunction

endpackage

// File: rtl/note_rec_sequencer_ram.sv
// Note storage: simple dual-port RAM with a synchronous write and a
// one-cycle registered read. The storage has no reset so it maps onto block RAM.
module note_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int NOTE_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [NOTE_W-1:0] rd_data
);

  logic [NOTE_W-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/note_rec_sequencer.sv
// Record/playback controller: records one key index per beat into the note RAM
// and replays the stored notes one per beat, with optional looping.
module note_rec_sequencer
  import note_rec_sequencer_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              loop_en,
  input  logic              beat_tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              note_in_valid,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_out_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);

  seq_state_t        cur_state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_n;
  logic [ADDR_W:0]   rec_len_n;
  logic              full_n;
  logic [NOTE_W-1:0] note_out_n;
  logic              note_out_valid_n;
  logic              rd_pending, rd_pending_n;
  logic              rec_prev, play_prev;
  logic              rec_rise, play_rise;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [NOTE_W-1:0] rd_data;

  assign rec_rise  = rec_en & ~rec_prev;
  assign play_rise = play_en & ~play_prev;
  assign state     = cur_state;

  note_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NOTE_W (NOTE_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rec_code(note_in_valid, note_in)),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state, pointer and output computation.
  always_comb begin
    state_n      = cur_state;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    rec_len_n    = rec_len;
    full_n       = full;
    note_out_n   = note_out;
    rd_pending_n = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    case (cur_state)
      S_IDLE: begin
        note_out_n = REST;
        if (rec_rise) begin
          state_n   = S_RECORD;
          wr_ptr_n  = '0;
          rec_len_n = '0;
          full_n    = 1'b0;
        end else if (play_rise && (rec_len != '0)) begin
          state_n  = S_PLAY;
          rd_ptr_n = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RECORD: begin
        note_out_n = REST;
        if (!rec_en) begin
          state_n = S_IDLE;
        end else if (beat_tick) begin
          wr_en     = 1'b1;
          wr_ptr_n  = wr_ptr + ADDR_W'(1);
          rec_len_n = {1'b0, wr_ptr} + (ADDR_W+1)'(1);
          // The write into the last slot ends the recording.
          if (wr_ptr == ADDR_W'(DEPTH-1)) begin
            full_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            full_n = 1'b0;
          end
        end else begin
          state_n = S_RECORD;
        end
      end
      S_PLAY: begin
        if (!play_en) begin
          state_n    = S_IDLE;
          note_out_n = REST;
        end else begin
          if (rd_pending) begin
            note_out_n = rd_data;
          end else begin
            note_out_n = note_out;
          end
          // Past the end: wrap to slot 0 when looping, otherwise finish on this beat.
          if (beat_tick) begin
            if (rd_ptr < rec_len) begin
              rd_en        = 1'b1;
              rd_addr      = rd_ptr[ADDR_W-1:0];
              rd_ptr_n     = rd_ptr + (ADDR_W+1)'(1);
              rd_pending_n = 1'b1;
            end else if (loop_en) begin
              rd_en        = 1'b1;
              rd_addr      = '0;
              rd_ptr_n     = (ADDR_W+1)'(1);
              rd_pending_n = 1'b1;
            end else begin
              state_n    = S_IDLE;
              note_out_n = REST;
            end
          end else begin
            rd_pending_n = rd_pending;
          end
        end
      end
      default: begin
        state_n    = S_IDLE;
        note_out_n = REST;
      end
    endcase
    note_out_valid_n = (state_n == S_PLAY) && (note_out_n != REST);
  end

  // State, pointer, edge-detector and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state      <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rec_len        <= '0;
      full           <= 1'b0;
      note_out       <= REST;
      note_out_valid <= 1'b0;
      rd_pending     <= 1'b0;
      rec_prev       <= 1'b1;
      play_prev      <= 1'b1;
    end else begin
      cur_state      <= state_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      rec_len        <= rec_len_n;
      full           <= full_n;
      note_out       <= note_out_n;
      note_out_valid <= note_out_valid_n;
      rd_pending     <= rd_pending_n;
      rec_prev       <= rec_en;
      play_prev      <= play_en;
    end
  end

endmodule

// File: tb/tb_note_rec_sequencer.sv
// Self-checking bench for note_rec_sequencer: a per-cycle vector table for
// record/play/priority, plus hand-written loop, abort, full and reset sequences.
module tb_note_rec_sequencer;
  import note_rec_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, rec_en, play_en, loop_en, beat_tick, note_in_valid;
  logic [5:0] note_in, note_out;
  logic       note_out_valid, full;
  logic [1:0] state;
  logic [9:0] rec_len;

  int errors = 0;
  int checks = 0;

  note_rec_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .rec_en         (rec_en),
    .play_en        (play_en),
    .loop_en        (loop_en),
    .beat_tick      (beat_tick),
    .note_in        (note_in),
    .note_in_valid  (note_in_valid),
    .note_out       (note_out),
    .note_out_valid (note_out_valid),
    .state          (state),
    .rec_len        (rec_len),
    .full           (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rec, play, lp, tick;
    logic [5:0] note;
    logic       nv;
    logic [1:0] e_state;
    logic [5:0] e_note;
    logic       e_nv;
    logic [9:0] e_len;
    logic       e_full;
  } vec_t;

  vec_t tv [25];

  function automatic vec_t mk(input logic r, input logic p, input logic l, input logic t,
                              input logic [5:0] n, input logic v, input logic [1:0] es,
                              input logic [5:0] en, input logic ev, input logic [9:0] el,
                              input logic ef);
    vec_t x;
    x.rec = r; x.play = p; x.lp = l; x.tick = t; x.note = n; x.nv = v;
    x.e_state = es; x.e_note = en; x.e_nv = ev; x.e_len = el; x.e_full = ef;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] got, exp_pack;
  int          bad;
  logic [5:0]  loop_exp [7];

  initial begin
    // {rec, play, loop, tick, note, valid} -> {state, note_out, valid, rec_len, full}
    tv[0]  = mk(1, 0, 0, 0,  0, 0, 2'd1, 63, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 1, 21, 1, 2'd1, 63, 0, 1, 0);
    tv[2]  = mk(1, 0, 0, 0,  0, 0, 2'd1, 63, 0, 1, 0);
    tv[3]  = mk(1, 0, 0, 1, 21, 1, 2'd1, 63, 0, 2, 0);
    tv[4]  = mk(1, 0, 0, 1, 40, 0, 2'd1, 63, 0, 3, 0);
    tv[5]  = mk(1, 0, 0, 1, 33, 1, 2'd1, 63, 0, 4, 0);
    tv[6]  = mk(0, 0, 0, 0,  0, 0, 2'd0, 63, 0, 4, 0);
    tv[7]  = mk(0, 1, 0, 0,  0, 0, 2'd2, 63, 0, 4, 0);
    tv[8]  = mk(0, 1, 0, 1,  0, 0, 2'd2, 63, 0, 4, 0);
    tv[9]  = mk(0, 1, 0, 0,  0, 0, 2'd2, 21, 1, 4, 0);
    tv[10] = mk(0, 1, 0, 1,  0, 0, 2'd2, 21, 1, 4, 0);
    tv[11] = mk(0, 1, 0, 0,  0, 0, 2'd2, 21, 1, 4, 0);
    tv[12] = mk(0, 1, 0, 1,  0, 0, 2'd2, 21, 1, 4, 0);
    tv[13] = mk(0, 1, 0, 0,  0, 0, 2'd2, 63, 0, 4, 0);
    tv[14] = mk(0, 1, 0, 1,  0, 0, 2'd2, 63, 0, 4, 0);
    tv[15] = mk(0, 1, 0, 0,  0, 0, 2'd2, 33, 1, 4, 0);
    tv[16] = mk(0, 1, 0, 0,  0, 0, 2'd2, 33, 1, 4, 0);
    tv[17] = mk(0, 1, 0, 1,  0, 0, 2'd0, 63, 0, 4, 0);
    tv[18] = mk(0, 1, 0, 0,  0, 0, 2'd0, 63, 0, 4, 0);
    tv[19] = mk(0, 0, 0, 0,  0, 0, 2'd0, 63, 0, 4, 0);
    tv[20] = mk(1, 1, 0, 0,  0, 0, 2'd1, 63, 0, 0, 0);
    tv[21] = mk(0, 1, 0, 0,  0, 0, 2'd0, 63, 0, 0, 0);
    tv[22] = mk(0, 0, 0, 0,  0, 0, 2'd0, 63, 0, 0, 0);
    tv[23] = mk(0, 1, 0, 0,  0, 0, 2'd0, 63, 0, 0, 0);
    tv[24] = mk(0, 0, 0, 0,  0, 0, 2'd0, 63, 0, 0, 0);
    loop_exp = '{6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd3, 6'd1};

    reset = 1'b0; rec_en = 1'b0; play_en = 1'b0; loop_en = 1'b0;
    beat_tick = 1'b0; note_in = 6'd0; note_in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("reset_state", {state, note_out, note_out_valid, rec_len, full},
          {2'd0, 6'd63, 1'b0, 10'd0, 1'b0});

    // Table: basic record/play, end of playback, priority and empty-play cases.
    for (int i = 0; i < 25; i++) begin
      rec_en = tv[i].rec; play_en = tv[i].play; loop_en = tv[i].lp;
      beat_tick = tv[i].tick; note_in = tv[i].note; note_in_valid = tv[i].nv;
      step();
      got      = {state, note_out, note_out_valid, rec_len, full};
      exp_pack = {tv[i].e_state, tv[i].e_note, tv[i].e_nv, tv[i].e_len, tv[i].e_full};
      check($sformatf("vec%0d", i), {12'd0, got}, {12'd0, exp_pack});
    end
    beat_tick = 1'b0; rec_en = 1'b0; play_en = 1'b0;

    // Loop: record 1,2,3 and replay 7 beats with wrap-around.
    rec_en = 1'b1; step();
    for (int i = 1; i <= 3; i++) begin
      note_in = 6'(i); note_in_valid = 1'b1; beat_tick = 1'b1; step();
      beat_tick = 1'b0; step();
    end
    rec_en = 1'b0; step();
    check("loop_rec_len", {22'd0, rec_len}, 32'd3);
    play_en = 1'b1; loop_en = 1'b1; step();
    for (int i = 0; i < 7; i++) begin
      beat_tick = 1'b1; step();
      beat_tick = 1'b0; step();
      check($sformatf("loop_note%0d", i), {26'd0, note_out}, {26'd0, loop_exp[i]});
      step();
    end
    check("loop_state_play", {30'd0, state}, 32'd2);
    check("loop_valid", {31'd0, note_out_valid}, 32'd1);

    // Abort with a read in flight: IDLE and REST on the next edge, read dropped.
    beat_tick = 1'b1; step();
    beat_tick = 1'b0; play_en = 1'b0; step();
    check("abort_state", {30'd0, state}, 32'd0);
    check("abort_note", {25'd0, note_out, note_out_valid}, {25'd0, 6'd63, 1'b0});
    step();
    check("abort_dropped", {26'd0, note_out}, 32'd63);
    loop_en = 1'b0;

    // Full stop: 515 ticks, only the first 512 are stored.
    rec_en = 1'b1; step();
    for (int i = 0; i < 515; i++) begin
      note_in = (i < 512) ? 6'd5 : 6'd9; note_in_valid = 1'b1; beat_tick = 1'b1;
      step();
      if (i == 511) begin
        check("full_at_512", {19'd0, state, rec_len, full}, {19'd0, 2'd0, 10'd512, 1'b1});
      end
    end
    beat_tick = 1'b0; rec_en = 1'b0; step();
    check("full_after_extra", {20'd0, rec_len, full}, {20'd0, 10'd512, 1'b1});
    play_en = 1'b1; step();
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      beat_tick = 1'b1; step();
      beat_tick = 1'b0; step();
      if (note_out !== 6'd5) bad++;
      step();
    end
    check("full_play_notes", bad, 0);
    beat_tick = 1'b1; step();
    beat_tick = 1'b0;
    check("full_play_end", {24'd0, state, note_out}, {24'd0, 2'd0, 6'd63});
    play_en = 1'b0; step();

    // Async reset in RECORD, then both switches held high across release.
    rec_en = 1'b1; step();
    note_in = 6'd7; beat_tick = 1'b1; step();
    beat_tick = 1'b0;
    check("rec_before_reset", {20'd0, state, rec_len}, {20'd0, 2'd1, 10'd1});
    #2 reset = 1'b0;
    #1 check("async_reset", {13'd0, state, note_out, note_out_valid, rec_len, full},
             {13'd0, 2'd0, 6'd63, 1'b0, 10'd0, 1'b0});
    play_en = 1'b1;
    step(); step();
    reset = 1'b1;
    repeat (3) step();
    check("held_switches", {20'd0, state, rec_len}, {20'd0, 2'd0, 10'd0});
    rec_en = 1'b0; play_en = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
